dma_apb_slave: RTL and testbench



---
 rtl/dma_apb_slave.sv | 186 ++++++++++++++++++
 tb/tb_dma_apb_slave.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_apb_slave.sv
// APB completer and register file for the single-channel DMA controller.
// Decodes APB accesses, holds the channel programming registers and runs the start/done handshake.
module dma_apb_slave #(
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] ID_VALUE    = 32'hD3A0_0001
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pclken,
  input  logic        psel,
  input  logic        penable,
  input  logic [12:0] paddr,
  input  logic        pwrite,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pslverr,
  output logic        pready,
  input  logic        scan_en,
  output logic        INT,
  output logic        idle,
  output logic [31:0] ch_src,
  output logic [31:0] ch_dst,
  output logic [15:0] ch_len,
  output logic        ch_start,
  input  logic        ch_done,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  state_t      state;
  logic [3:0]  wait_cnt;

  logic [31:0] src_q;
  logic [31:0] dst_q;
  logic [15:0] len_q;
  logic        int_en_q;
  logic        busy_q;
  logic        done_q;
  logic        start_q;

  logic        pready_q;
  logic [31:0] prdata_q;
  logic        pslverr_q;

  // Write captured at the start of RESP, applied on the RESP completion edge.
  logic        cm_write;
  logic [2:0]  cm_idx;
  logic [31:0] cm_data;

  logic        advance;
  logic        setup;
  logic        enter_resp;
  logic        commit;
  logic [2:0]  idx;
  logic        addr_ok;
  logic        dec_err;
  logic [31:0] dec_rdata;

  assign advance    = pclken && !scan_en;
  assign setup      = (state == ST_IDLE) && psel && !penable;
  assign enter_resp = (setup && (WS == 4'd0)) ||
                      ((state == ST_WAIT) && psel && penable && (wait_cnt == 4'd1));
  assign commit     = (state == ST_RESP) && cm_write && !pslverr_q;

  assign idx     = paddr[4:2];
  assign addr_ok = (paddr[1:0] == 2'b00) && (paddr <= 13'h014);

  // A START write while busy is rejected whole, so INT_EN keeps its value too.
  assign dec_err = !addr_ok ||
                   (pwrite && (idx == 3'd5)) ||
                   (pwrite && (idx == 3'd3) && pwdata[0] && busy_q);

  always_comb begin
    dec_rdata = 32'd0;
    if (!pwrite && !dec_err) begin
      unique case (idx)
        3'd0:    dec_rdata = src_q;
        3'd1:    dec_rdata = dst_q;
        3'd2:    dec_rdata = {16'd0, len_q};
        3'd3:    dec_rdata = {30'd0, int_en_q, busy_q};
        3'd4:    dec_rdata = {31'd0, done_q};
        3'd5:    dec_rdata = ID_VALUE;
        default: dec_rdata = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      wait_cnt  <= 4'd0;
      src_q     <= 32'd0;
      dst_q     <= 32'd0;
      len_q     <= 16'd0;
      int_en_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      start_q   <= 1'b0;
      pready_q  <= 1'b0;
      prdata_q  <= 32'd0;
      pslverr_q <= 1'b0;
      cm_write  <= 1'b0;
      cm_idx    <= 3'd0;
      cm_data   <= 32'd0;
    end else begin
      start_q <= 1'b0;
      if (advance) begin
        if (enter_resp) begin
          state     <= ST_RESP;
          pready_q  <= 1'b1;
          prdata_q  <= dec_rdata;
          pslverr_q <= dec_err;
          cm_write  <= pwrite;
          cm_idx    <= idx;
          cm_data   <= pwdata;
        end else begin
          unique case (state)
            ST_IDLE: begin
              if (setup) begin
                state    <= ST_WAIT;
                wait_cnt <= WS;
              end
            end
            ST_WAIT: begin
              if (!psel) begin
                state <= ST_IDLE;
              end else if (penable) begin
                wait_cnt <= wait_cnt - 4'd1;
              end
            end
            ST_RESP: begin
              state     <= ST_IDLE;
              pready_q  <= 1'b0;
              prdata_q  <= 32'd0;
              pslverr_q <= 1'b0;
              cm_write  <= 1'b0;
            end
            default: state <= ST_IDLE;
          endcase
        end

        if (commit) begin
          unique case (cm_idx)
            3'd0: src_q <= cm_data;
            3'd1: dst_q <= cm_data;
            3'd2: len_q <= cm_data[15:0];
            3'd3: begin
              int_en_q <= cm_data[1];
              if (cm_data[0]) begin
                busy_q  <= 1'b1;
                start_q <= 1'b1;
              end
            end
            3'd4: if (cm_data[0]) done_q <= 1'b0;
            default: ;
          endcase
        end

        // Placed after the W1C so a completion in the same cycle keeps DONE set.
        if (ch_done && busy_q) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign pready    = scan_en | pready_q;
  assign prdata    = scan_en ? 32'd0 : prdata_q;
  assign pslverr   = !scan_en && pslverr_q;
  assign INT       = done_q & int_en_q;
  assign idle      = !busy_q;
  assign ch_src    = src_q;
  assign ch_dst    = dst_q;
  assign ch_len    = len_q;
  assign ch_start  = start_q && !scan_en;
  assign dbg_state = state;

endmodule

// File: tb/tb_dma_apb_slave.sv
// Self-checking bench for dma_apb_slave: directed plan steps plus randomized APB traffic
// against a transaction-level register model.
module tb_dma_apb_slave;

  localparam int          WS = 2;
  localparam logic [31:0] ID = 32'hD3A0_0001;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pclken = 1'b1;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic [12:0] paddr = 13'd0;
  logic        pwrite = 1'b0;
  logic [31:0] pwdata = 32'd0;
  logic        scan_en = 1'b0;
  logic        ch_done = 1'b0;
  logic [31:0] prdata;
  logic        pslverr;
  logic        pready;
  logic        INT;
  logic        idle;
  logic [31:0] ch_src;
  logic [31:0] ch_dst;
  logic [15:0] ch_len;
  logic        ch_start;
  logic [1:0]  dbg_state;

  dma_apb_slave #(.WAIT_STATES(WS), .ID_VALUE(ID)) dut (
    .clk(clk), .reset(reset), .pclken(pclken), .psel(psel), .penable(penable),
    .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata),
    .pslverr(pslverr), .pready(pready), .scan_en(scan_en), .INT(INT), .idle(idle),
    .ch_src(ch_src), .ch_dst(ch_dst), .ch_len(ch_len), .ch_start(ch_start),
    .ch_done(ch_done), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_src, m_dst;
  logic [15:0] m_len;
  logic        m_int_en, m_busy, m_done;
  int          start_at = -1;
  bit          mon_on = 0;
  bit          in_xfer = 0;

  task automatic model_reset();
    m_src = 0; m_dst = 0; m_len = 0;
    m_int_en = 0; m_busy = 0; m_done = 0;
    start_at = -1;
  endtask

  function automatic logic m_err(input logic wr, input logic [12:0] a, input logic [31:0] d);
    return (a[1:0] != 2'b00) || (a > 13'h014) || (wr && a == 13'h014) ||
           (wr && a == 13'h00C && d[0] && m_busy);
  endfunction

  function automatic logic [31:0] m_read(input logic [12:0] a);
    case (a)
      13'h000: return m_src;
      13'h004: return m_dst;
      13'h008: return {16'd0, m_len};
      13'h00C: return {30'd0, m_int_en, m_busy};
      13'h010: return {31'd0, m_done};
      13'h014: return ID;
      default: return 32'd0;
    endcase
  endfunction

  // Applied right after the commit edge; cyc then names the cycle that follows it.
  task automatic model_write(input logic [12:0] a, input logic [31:0] d);
    case (a)
      13'h000: m_src = d;
      13'h004: m_dst = d;
      13'h008: m_len = d[15:0];
      13'h00C: begin
        m_int_en = d[1];
        if (d[0]) begin
          m_busy = 1;
          start_at = cyc;
        end
      end
      13'h010: if (d[0]) m_done = 0;
      default: ;
    endcase
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (mon_on) begin
      chk("int", 32'(INT), 32'(m_done & m_int_en));
      chk("idle", 32'(idle), 32'(!m_busy));
      chk("ch_src", ch_src, m_src);
      chk("ch_dst", ch_dst, m_dst);
      chk("ch_len", 32'(ch_len), 32'(m_len));
      chk("ch_start", 32'(ch_start), 32'(cyc == start_at));
      if (!in_xfer && !scan_en) begin
        chk("pready_quiet", 32'(pready), 32'd0);
        chk("prdata_quiet", prdata, 32'd0);
        chk("pslverr_quiet", 32'(pslverr), 32'd0);
      end
    end
  end

  // ---------------- driver tasks (entered and left at posedge+1) ----------------
  task automatic sync();
    @(posedge clk); #1;
  endtask

  task automatic apb_xfer(input logic wr, input logic [12:0] a, input logic [31:0] d,
                          input int stalls, input logic done_at_resp,
                          output logic [31:0] rdata, output logic err, output int lat);
    logic exp_err;
    logic b0;
    int   eff;
    int   st;
    bit   fin;
    exp_err = m_err(wr, a, d);
    if (!wr && !exp_err) exp_q.push_back(m_read(a));
    in_xfer = 1;
    psel = 1; penable = 0; pclken = 1; paddr = a; pwrite = wr; pwdata = d;
    lat = 1;
    @(negedge clk);
    chk("pready_setup", 32'(pready), 32'd0);
    sync();
    penable = 1;
    eff = 0; st = stalls; fin = 0;
    rdata = 0; err = 0;
    while (!fin) begin
      lat++;
      if (eff == 0 && st > 0) begin
        pclken = 0;
        st--;
      end else begin
        pclken = 1;
      end
      if (eff == WS) ch_done = done_at_resp;
      @(negedge clk);
      chk("pready_access", 32'(pready), 32'(eff == WS));
      if (eff == WS) begin
        rdata = prdata;
        err = pslverr;
        chk("pslverr", 32'(pslverr), 32'(exp_err));
        if (!wr && !exp_err) chk("prdata", prdata, exp_q.pop_front());
        fin = 1;
      end else begin
        chk("prdata_wait", prdata, 32'd0);
      end
      sync();
      if (pclken) eff++;
    end
    psel = 0; penable = 0; ch_done = 0; pclken = 1;
    b0 = m_busy;
    if (wr && !exp_err) model_write(a, d);
    if (done_at_resp && b0) begin
      m_busy = 0;
      m_done = 1;
    end
    in_xfer = 0;
  endtask

  task automatic pulse_done();
    ch_done = 1;
    sync();
    ch_done = 0;
    if (m_busy) begin
      m_busy = 0;
      m_done = 1;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          addrs[9] = '{'h000, 'h004, 'h008, 'h00C, 'h010, 'h014, 'h018, 'h002, 'h1FFC};
    logic [12:0] a;
    logic        wr;

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    mon_on = 1;

    // Reset values.
    @(negedge clk);
    chk("rst_pready", 32'(pready), 32'd0);
    chk("rst_prdata", prdata, 32'd0);
    chk("rst_pslverr", 32'(pslverr), 32'd0);
    chk("rst_int", 32'(INT), 32'd0);
    chk("rst_idle", 32'(idle), 32'd1);
    chk("rst_ch_start", 32'(ch_start), 32'd0);
    chk("rst_ch_src", ch_src, 32'd0);
    chk("rst_ch_len", 32'(ch_len), 32'd0);
    sync();

    // ID read and latency.
    apb_xfer(0, 13'h014, 32'd0, 0, 0, rd, er, lat);
    chk("id_data", rd, 32'hD3A0_0001);
    chk("id_err", 32'(er), 32'd0);
    chk("id_latency", 32'(lat), 32'd4);

    // SRC write / read back, error accesses leave it alone.
    apb_xfer(1, 13'h000, 32'h1000_0000, 0, 0, rd, er, lat);
    apb_xfer(0, 13'h000, 32'd0, 0, 0, rd, er, lat);
    chk("src_read", rd, 32'h1000_0000);
    chk("src_port", ch_src, 32'h1000_0000);
    apb_xfer(1, 13'h002, 32'hFFFF_FFFF, 0, 0, rd, er, lat);
    chk("misaligned_err", 32'(er), 32'd1);
    apb_xfer(1, 13'h018, 32'hFFFF_FFFF, 0, 0, rd, er, lat);
    chk("oob_err", 32'(er), 32'd1);
    apb_xfer(1, 13'h014, 32'hFFFF_FFFF, 0, 0, rd, er, lat);
    chk("id_write_err", 32'(er), 32'd1);
    apb_xfer(0, 13'h000, 32'd0, 0, 0, rd, er, lat);
    chk("src_unchanged", rd, 32'h1000_0000);

    // LEN + START.
    apb_xfer(1, 13'h008, 32'hABCD_0040, 0, 0, rd, er, lat);
    chk("len_port", 32'(ch_len), 32'h40);
    apb_xfer(1, 13'h00C, 32'h3, 0, 0, rd, er, lat);
    @(negedge clk);
    chk("start_pulse", 32'(ch_start), 32'd1);
    chk("busy_idle", 32'(idle), 32'd0);
    sync();
    apb_xfer(0, 13'h00C, 32'd0, 0, 0, rd, er, lat);
    chk("ctrl_read", rd, 32'h3);
    apb_xfer(1, 13'h00C, 32'h1, 0, 0, rd, er, lat);
    chk("start_busy_err", 32'(er), 32'd1);

    // Completion, INT, W1C, and set-wins collision.
    pulse_done();
    @(negedge clk);
    chk("done_idle", 32'(idle), 32'd1);
    chk("done_int", 32'(INT), 32'd1);
    sync();
    apb_xfer(0, 13'h010, 32'd0, 0, 0, rd, er, lat);
    chk("status_read", rd, 32'h1);
    apb_xfer(1, 13'h010, 32'h1, 0, 0, rd, er, lat);
    @(negedge clk);
    chk("w1c_int", 32'(INT), 32'd0);
    sync();
    apb_xfer(1, 13'h00C, 32'h3, 0, 0, rd, er, lat);
    apb_xfer(1, 13'h010, 32'h1, 0, 1, rd, er, lat);
    apb_xfer(0, 13'h010, 32'd0, 0, 0, rd, er, lat);
    chk("status_set_wins", rd, 32'h1);
    chk("collide_idle", 32'(idle), 32'd1);

    // pclken stall during WAIT.
    apb_xfer(0, 13'h000, 32'd0, 3, 0, rd, er, lat);
    chk("stall_latency", 32'(lat), 32'd7);
    chk("stall_data", rd, 32'h1000_0000);

    // Randomized traffic.
    for (int i = 0; i < 120; i++) begin
      a = 13'(addrs[$urandom_range(0, 8)]);
      wr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) pulse_done();
      apb_xfer(wr, a, $urandom, $urandom_range(0, 3), 1'($urandom_range(0, 7) == 0), rd, er, lat);
      if ($urandom_range(0, 1) == 0) sync();
    end

    // Reset during WAIT of a SRC write.
    apb_xfer(1, 13'h000, 32'h1234_5678, 0, 0, rd, er, lat);
    psel = 1; penable = 0; pwrite = 1; paddr = 13'h000; pwdata = 32'hDEAD_BEEF;
    sync();
    penable = 1;
    sync();
    reset = 1;
    sync();
    reset = 0; psel = 0; penable = 0;
    model_reset();
    @(negedge clk);
    chk("rst_mid_pready", 32'(pready), 32'd0);
    chk("rst_mid_src", ch_src, 32'd0);
    sync();
    apb_xfer(0, 13'h000, 32'd0, 0, 0, rd, er, lat);
    chk("rst_mid_src_read", rd, 32'd0);

    // Scan mode: forced response, no register update.
    scan_en = 1;
    psel = 1; penable = 0; pwrite = 1; paddr = 13'h000; pwdata = 32'hCAFE_F00D;
    sync();
    penable = 1;
    repeat (3) begin
      @(negedge clk);
      chk("scan_pready", 32'(pready), 32'd1);
      chk("scan_prdata", prdata, 32'd0);
      chk("scan_pslverr", 32'(pslverr), 32'd0);
      sync();
    end
    psel = 0; penable = 0; scan_en = 0;
    sync();
    apb_xfer(0, 13'h000, 32'd0, 0, 0, rd, er, lat);
    chk("scan_src_unchanged", rd, 32'd0);

    sync();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
